brick_field: RTL and testbench

- Parametrised brick-wall unit for the Breakout video path. It replaces the fixed 6x5 combinational brick renderer.
- Holds the alive/dead state of every brick in registers.
- Renders the wall through a 2-stage pixel pipeline.
- Resolves ball-contact queries from the ball/physics logic through a valid/ready hit handshake, clearing struck bricks and tracking bricks remaining.
- Sits between the VGA timing generator (xIndex/yIndex/displayEnable) and the pixel mux; also feeds game-state logic.

---
 rtl/brick_pkg.sv | 44 ++++
 rtl/brick_locator.sv | 63 ++++++
 rtl/brick_field.sv | 206 ++++++++++++++++++++
 tb/tb_brick_field.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Geometry defaults, palette, FSM states and helpers for the brick wall.
package brick_pkg;

    localparam int DEF_COLS    = 6;
    localparam int DEF_ROWS    = 5;
    localparam int DEF_START_X = 20;
    localparam int DEF_START_Y = 20;
    localparam int DEF_BRICK_W = 100;
    localparam int DEF_BRICK_H = 20;
    localparam int DEF_GAP     = 0;

    localparam logic [7:0] RED    = 8'hC0;
    localparam logic [7:0] ORANGE = 8'hCC;
    localparam logic [7:0] YELLOW = 8'hD8;
    localparam logic [7:0] GREEN  = 8'h18;
    localparam logic [7:0] BLUE   = 8'h03;
    localparam logic [7:0] BLACK  = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESOLVE
    } hit_state_t;

    // Never returns 0 so single-row/column builds keep 1-bit indices.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int popcount(input logic [255:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/brick_locator.sv
// Maps a pixel to its brick row/column and mortar flag with comparator chains.
module brick_locator
    import brick_pkg::*;
#(
    parameter int NUM_COLS = DEF_COLS,
    parameter int NUM_ROWS = DEF_ROWS,
    parameter int START_X  = DEF_START_X,
    parameter int START_Y  = DEF_START_Y,
    parameter int BRICK_W  = DEF_BRICK_W,
    parameter int BRICK_H  = DEF_BRICK_H,
    parameter int GAP      = DEF_GAP,
    parameter int RW       = 3,
    parameter int CW       = 3
) (
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    output logic          inRegion,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          mortar
);

    int            xi;
    int            yi;
    logic          in_x;
    logic          in_y;
    logic          mort_x;
    logic          mort_y;
    logic [RW-1:0] row_v;
    logic [CW-1:0] col_v;

    always_comb begin
        xi     = int'(x);
        yi     = int'(y);
        in_x   = 1'b0;
        in_y   = 1'b0;
        mort_x = 1'b0;
        mort_y = 1'b0;
        row_v  = '0;
        col_v  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (xi >= START_X + c * BRICK_W &&
                xi < START_X + (c + 1) * BRICK_W) begin
                in_x   = 1'b1;
                col_v  = CW'(c);
                mort_x = xi >= START_X + (c + 1) * BRICK_W - GAP;
            end
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (yi >= START_Y + r * BRICK_H &&
                yi < START_Y + (r + 1) * BRICK_H) begin
                in_y   = 1'b1;
                row_v  = RW'(r);
                mort_y = yi >= START_Y + (r + 1) * BRICK_H - GAP;
            end
        end
        inRegion = in_x && in_y;
        row      = inRegion ? row_v : '0;
        col      = inRegion ? col_v : '0;
        mortar   = inRegion && (mort_x || mort_y);
    end

endmodule

// File: rtl/brick_field.sv
// Brick wall state, 2-stage pixel renderer and hit-query resolver.
module brick_field
    import brick_pkg::*;
#(
    parameter int NUM_COLS = DEF_COLS,
    parameter int NUM_ROWS = DEF_ROWS,
    parameter int START_X  = DEF_START_X,
    parameter int START_Y  = DEF_START_Y,
    parameter int BRICK_W  = DEF_BRICK_W,
    parameter int BRICK_H  = DEF_BRICK_H,
    parameter int GAP      = DEF_GAP,
    parameter logic [NUM_ROWS*8-1:0] ROW_COLORS =
        {BLUE, GREEN, YELLOW, ORANGE, RED},
    parameter logic [NUM_ROWS*NUM_COLS-1:0] RESET_MASK = '1
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic [9:0]                         xIndex,
    input  logic [9:0]                         yIndex,
    input  logic                               displayEnable,
    input  logic                               loadLevel,
    input  logic [NUM_ROWS*NUM_COLS-1:0]       levelMask,
    input  logic                               hitValid,
    input  logic [9:0]                         hitX,
    input  logic [9:0]                         hitY,
    output logic                               hitReady,
    output logic                               hitDone,
    output logic                               hitBrick,
    output logic [clog2(NUM_ROWS)-1:0]         hitRow,
    output logic [clog2(NUM_COLS)-1:0]         hitCol,
    output logic [NUM_ROWS*NUM_COLS-1:0]       bricksAlive,
    output logic [clog2(NUM_ROWS*NUM_COLS+1)-1:0] bricksRemaining,
    output logic                               allCleared,
    output logic [7:0]                         color,
    output logic                               shouldDisplay
);

    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int RW = clog2(NUM_ROWS);
    localparam int CW = clog2(NUM_COLS);
    localparam int IW = clog2(N);
    localparam int NW = clog2(N + 1);
    localparam logic [NW-1:0] RESET_CNT = NW'(popcount(256'(RESET_MASK)));

    logic          p_in, p_mort, h_in, h_mort;
    logic [RW-1:0] p_row, h_row;
    logic [CW-1:0] p_col, h_col;

    hit_state_t    state_q, state_d;
    logic [9:0]    hx_q, hx_d, hy_q, hy_d;
    logic          l_in_q, l_in_d, l_mort_q, l_mort_d;
    logic [RW-1:0] l_row_q, l_row_d, hrow_q, hrow_d;
    logic [CW-1:0] l_col_q, l_col_d, hcol_q, hcol_d;
    logic [N-1:0]  alive_q, alive_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          done_q, done_d, brick_q, brick_d;
    logic          s1_vld_q, s1_vld_d, s1_mort_q, s1_mort_d;
    logic [RW-1:0] s1_row_q, s1_row_d;
    logic [CW-1:0] s1_col_q, s1_col_d;
    logic          sd_q, sd_d;
    logic [7:0]    color_q, color_d;
    logic [IW-1:0] p_idx, l_idx;

    brick_locator #(
        .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS),
        .START_X(START_X), .START_Y(START_Y),
        .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
        .GAP(GAP), .RW(RW), .CW(CW)
    ) u_pix_loc (
        .x(xIndex), .y(yIndex), .inRegion(p_in),
        .row(p_row), .col(p_col), .mortar(p_mort)
    );

    brick_locator #(
        .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS),
        .START_X(START_X), .START_Y(START_Y),
        .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
        .GAP(GAP), .RW(RW), .CW(CW)
    ) u_hit_loc (
        .x(hx_q), .y(hy_q), .inRegion(h_in),
        .row(h_row), .col(h_col), .mortar(h_mort)
    );

    assign p_idx = IW'(int'(s1_row_q) * NUM_COLS + int'(s1_col_q));
    assign l_idx = IW'(int'(l_row_q) * NUM_COLS + int'(l_col_q));

    always_comb begin
        s1_vld_d  = p_in && displayEnable;
        s1_row_d  = p_row;
        s1_col_d  = p_col;
        s1_mort_d = p_mort;
        sd_d      = s1_vld_q;
        color_d   = BLACK;
        if (s1_vld_q && !s1_mort_q && alive_q[p_idx]) begin
            color_d = ROW_COLORS[8*int'(s1_row_q) +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        l_in_d   = l_in_q;
        l_mort_d = l_mort_q;
        l_row_d  = l_row_q;
        l_col_d  = l_col_q;
        alive_d  = alive_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        brick_d  = brick_q;
        hrow_d   = hrow_q;
        hcol_d   = hcol_q;
        // A level load wins over everything and silently drops any query.
        if (loadLevel) begin
            alive_d = levelMask;
            rem_d   = NW'(popcount(256'(levelMask)));
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hitValid) begin
                        hx_d    = hitX;
                        hy_d    = hitY;
                        state_d = LOOKUP;
                    end
                end
                LOOKUP: begin
                    l_in_d   = h_in;
                    l_mort_d = h_mort;
                    l_row_d  = h_row;
                    l_col_d  = h_col;
                    state_d  = RESOLVE;
                end
                RESOLVE: begin
                    brick_d = 1'b0;
                    if (l_in_q && !l_mort_q && alive_q[l_idx]) begin
                        alive_d[l_idx] = 1'b0;
                        rem_d          = rem_q - NW'(1);
                        brick_d        = 1'b1;
                    end
                    hrow_d  = l_row_q;
                    hcol_d  = l_col_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            hx_q      <= '0;
            hy_q      <= '0;
            l_in_q    <= 1'b0;
            l_mort_q  <= 1'b0;
            l_row_q   <= '0;
            l_col_q   <= '0;
            alive_q   <= RESET_MASK;
            rem_q     <= RESET_CNT;
            done_q    <= 1'b0;
            brick_q   <= 1'b0;
            hrow_q    <= '0;
            hcol_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            s1_mort_q <= 1'b0;
            sd_q      <= 1'b0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            l_in_q    <= l_in_d;
            l_mort_q  <= l_mort_d;
            l_row_q   <= l_row_d;
            l_col_q   <= l_col_d;
            alive_q   <= alive_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            brick_q   <= brick_d;
            hrow_q    <= hrow_d;
            hcol_q    <= hcol_d;
            s1_vld_q  <= s1_vld_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            s1_mort_q <= s1_mort_d;
            sd_q      <= sd_d;
            color_q   <= color_d;
        end
    end

    assign hitReady        = state_q == IDLE;
    assign hitDone         = done_q;
    assign hitBrick        = brick_q;
    assign hitRow          = hrow_q;
    assign hitCol          = hcol_q;
    assign bricksAlive     = alive_q;
    assign bricksRemaining = rem_q;
    assign allCleared      = rem_q == '0;
    assign color           = color_q;
    assign shouldDisplay   = sd_q;

endmodule

// File: tb/tb_brick_field.sv
// Directed checks of the brick wall: pixels, hits, level loads, reset, mortar.
module tb_brick_field;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [9:0]  xIndex = '0;
    logic [9:0]  yIndex = '0;
    logic        displayEnable = 1'b0;
    logic        loadLevel = 1'b0;
    logic [29:0] levelMask = '0;
    logic        hitValid = 1'b0;
    logic [9:0]  hitX = '0;
    logic [9:0]  hitY = '0;

    logic        hitReady, hitDone, hitBrick, allCleared, shouldDisplay;
    logic [2:0]  hitRow, hitCol;
    logic [29:0] bricksAlive;
    logic [4:0]  bricksRemaining;
    logic [7:0]  color;

    logic        g_ready, g_done, g_brick, g_clr, g_sd;
    logic [2:0]  g_row, g_col;
    logic [29:0] g_alive;
    logic [4:0]  g_rem;
    logic [7:0]  g_color;

    int checks = 0;
    int errors = 0;

    logic       s_brick;
    logic [2:0] s_row, s_col;
    int         s_lat, s_done, s_rdylow;

    always #5 clk = ~clk;

    brick_field dut (
        .clk(clk), .rstN(rstN), .xIndex(xIndex), .yIndex(yIndex),
        .displayEnable(displayEnable), .loadLevel(loadLevel),
        .levelMask(levelMask), .hitValid(hitValid), .hitX(hitX),
        .hitY(hitY), .hitReady(hitReady), .hitDone(hitDone),
        .hitBrick(hitBrick), .hitRow(hitRow), .hitCol(hitCol),
        .bricksAlive(bricksAlive), .bricksRemaining(bricksRemaining),
        .allCleared(allCleared), .color(color),
        .shouldDisplay(shouldDisplay)
    );

    brick_field #(.GAP(2)) dut_gap (
        .clk(clk), .rstN(rstN), .xIndex(xIndex), .yIndex(yIndex),
        .displayEnable(displayEnable), .loadLevel(loadLevel),
        .levelMask(levelMask), .hitValid(hitValid), .hitX(hitX),
        .hitY(hitY), .hitReady(g_ready), .hitDone(g_done),
        .hitBrick(g_brick), .hitRow(g_row), .hitCol(g_col),
        .bricksAlive(g_alive), .bricksRemaining(g_rem),
        .allCleared(g_clr), .color(g_color), .shouldDisplay(g_sd)
    );

    task automatic show_pixel(input [9:0] x, input [9:0] y, input de);
        @(negedge clk);
        xIndex = x;
        yIndex = y;
        displayEnable = de;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input [29:0] mask);
        @(negedge clk);
        levelMask = mask;
        loadLevel = 1'b1;
        @(posedge clk);
        #1 loadLevel = 1'b0;
    endtask

    task automatic send_hit(input [9:0] x, input [9:0] y);
        @(negedge clk);
        hitX = x;
        hitY = y;
        hitValid = 1'b1;
        @(posedge clk);
        #1 hitValid = 1'b0;
        s_lat = 0;
        s_done = 0;
        s_rdylow = 0;
        s_brick = 1'b0;
        s_row = '0;
        s_col = '0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (!hitReady) s_rdylow++;
            if (hitDone) begin
                s_done++;
                if (s_lat == 0) begin
                    s_lat = i;
                    s_brick = hitBrick;
                    s_row = hitRow;
                    s_col = hitCol;
                end
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (bricksAlive !== 30'h3FFF_FFFF) begin errors++; $display("FAIL rst_alive got %h want %h", bricksAlive, 30'h3FFF_FFFF); end
        checks++; if (bricksRemaining !== 5'd30) begin errors++; $display("FAIL rst_rem got %0d want 30", bricksRemaining); end
        checks++; if (hitReady !== 1'b1 || hitDone !== 1'b0) begin errors++; $display("FAIL rst_hs got rdy=%b done=%b want 1 0", hitReady, hitDone); end
        checks++; if (color !== 8'h00 || shouldDisplay !== 1'b0 || allCleared !== 1'b0) begin errors++; $display("FAIL rst_out got c=%h sd=%b clr=%b want 00 0 0", color, shouldDisplay, allCleared); end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_pixel;
        show_pixel(10'd25, 10'd25, 1'b1);
        checks++; if (shouldDisplay !== 1'b1 || color !== 8'hC0) begin errors++; $display("FAIL pix_25_25 got sd=%b c=%h want 1 c0", shouldDisplay, color); end
        show_pixel(10'd619, 10'd25, 1'b1);
        checks++; if (shouldDisplay !== 1'b1 || color !== 8'hC0) begin errors++; $display("FAIL pix_619_25 got sd=%b c=%h want 1 c0", shouldDisplay, color); end
        show_pixel(10'd620, 10'd25, 1'b1);
        checks++; if (shouldDisplay !== 1'b0 || color !== 8'h00) begin errors++; $display("FAIL pix_620_25 got sd=%b c=%h want 0 00", shouldDisplay, color); end
        show_pixel(10'd25, 10'd120, 1'b1);
        checks++; if (shouldDisplay !== 1'b0 || color !== 8'h00) begin errors++; $display("FAIL pix_25_120 got sd=%b c=%h want 0 00", shouldDisplay, color); end
        show_pixel(10'd25, 10'd105, 1'b1);
        checks++; if (shouldDisplay !== 1'b1 || color !== 8'h03) begin errors++; $display("FAIL pix_row4 got sd=%b c=%h want 1 03", shouldDisplay, color); end
        show_pixel(10'd250, 10'd65, 1'b1);
        checks++; if (shouldDisplay !== 1'b1 || color !== 8'hD8) begin errors++; $display("FAIL pix_row2 got sd=%b c=%h want 1 d8", shouldDisplay, color); end
        show_pixel(10'd25, 10'd25, 1'b0);
        checks++; if (shouldDisplay !== 1'b0 || color !== 8'h00) begin errors++; $display("FAIL pix_blank got sd=%b c=%h want 0 00", shouldDisplay, color); end
        // latency: the first cycle after a change must still show the old pixel
        @(negedge clk);
        xIndex = 10'd25;
        yIndex = 10'd25;
        displayEnable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (shouldDisplay !== 1'b0) begin errors++; $display("FAIL pix_latency got sd=%b want 0", shouldDisplay); end
        displayEnable = 1'b0;
    endtask

    task automatic test_hit;
        send_hit(10'd250, 10'd65);
        checks++; if (s_lat !== 3 || s_done !== 1) begin errors++; $display("FAIL hit_lat got lat=%0d n=%0d want 3 1", s_lat, s_done); end
        checks++; if (s_brick !== 1'b1 || s_row !== 3'd2 || s_col !== 3'd2) begin errors++; $display("FAIL hit_res got b=%b r=%0d c=%0d want 1 2 2", s_brick, s_row, s_col); end
        checks++; if (s_rdylow !== 2) begin errors++; $display("FAIL hit_ready got %0d want 2", s_rdylow); end
        checks++; if (bricksAlive !== 30'h3FFF_BFFF || bricksRemaining !== 5'd29) begin errors++; $display("FAIL hit_state got a=%h r=%0d want 3fffbfff 29", bricksAlive, bricksRemaining); end
        send_hit(10'd250, 10'd65);
        checks++; if (s_done !== 1 || s_brick !== 1'b0 || bricksRemaining !== 5'd29) begin errors++; $display("FAIL hit_again got n=%0d b=%b r=%0d want 1 0 29", s_done, s_brick, bricksRemaining); end
        show_pixel(10'd250, 10'd65, 1'b1);
        checks++; if (shouldDisplay !== 1'b1 || color !== 8'h00) begin errors++; $display("FAIL hit_pix got sd=%b c=%h want 1 00", shouldDisplay, color); end
        displayEnable = 1'b0;
    endtask

    task automatic test_level;
        load(30'h1);
        @(negedge clk);
        checks++; if (bricksRemaining !== 5'd1 || bricksAlive !== 30'h1) begin errors++; $display("FAIL lvl_load got r=%0d a=%h want 1 1", bricksRemaining, bricksAlive); end
        send_hit(10'd30, 10'd30);
        checks++; if (s_brick !== 1'b1 || allCleared !== 1'b1 || bricksRemaining !== 5'd0) begin errors++; $display("FAIL lvl_clear got b=%b clr=%b r=%0d want 1 1 0", s_brick, allCleared, bricksRemaining); end
        send_hit(10'd10, 10'd10);
        checks++; if (s_done !== 1 || s_brick !== 1'b0 || s_row !== 3'd0 || s_col !== 3'd0) begin errors++; $display("FAIL lvl_miss got n=%0d b=%b r=%0d c=%0d want 1 0 0 0", s_done, s_brick, s_row, s_col); end
        checks++; if (bricksRemaining !== 5'd0) begin errors++; $display("FAIL lvl_floor got %0d want 0", bricksRemaining); end
    endtask

    task automatic test_load_collide;
        int seen;
        @(negedge clk);
        levelMask = 30'h3FFF_FFFF;
        loadLevel = 1'b1;
        hitX = 10'd250;
        hitY = 10'd65;
        hitValid = 1'b1;
        @(posedge clk);
        #1;
        loadLevel = 1'b0;
        hitValid = 1'b0;
        seen = 0;
        @(negedge clk);
        checks++; if (hitReady !== 1'b1) begin errors++; $display("FAIL col_ready got %b want 1", hitReady); end
        repeat (4) begin
            @(negedge clk);
            if (hitDone) seen++;
        end
        checks++; if (seen !== 0 || bricksRemaining !== 5'd30) begin errors++; $display("FAIL col_drop got n=%0d r=%0d want 0 30", seen, bricksRemaining); end
    endtask

    task automatic test_load_lookup;
        int seen;
        @(negedge clk);
        hitX = 10'd250;
        hitY = 10'd65;
        hitValid = 1'b1;
        @(posedge clk);
        #1 hitValid = 1'b0;
        @(negedge clk);
        levelMask = 30'h0000_4000;
        loadLevel = 1'b1;
        @(posedge clk);
        #1 loadLevel = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (hitDone) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL lk_done got %0d want 0", seen); end
        checks++; if (bricksAlive !== 30'h0000_4000 || bricksRemaining !== 5'd1 || hitReady !== 1'b1) begin errors++; $display("FAIL lk_state got a=%h r=%0d rdy=%b want 4000 1 1", bricksAlive, bricksRemaining, hitReady); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        hitX = 10'd250;
        hitY = 10'd65;
        hitValid = 1'b1;
        @(posedge clk);
        #1 hitValid = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        checks++; if (bricksAlive !== 30'h3FFF_FFFF || bricksRemaining !== 5'd30) begin errors++; $display("FAIL rm_state got a=%h r=%0d want 3fffffff 30", bricksAlive, bricksRemaining); end
        checks++; if (hitReady !== 1'b1 || hitDone !== 1'b0) begin errors++; $display("FAIL rm_hs got rdy=%b done=%b want 1 0", hitReady, hitDone); end
        @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (hitDone) seen++;
        end
        checks++; if (seen !== 0 || bricksAlive[14] !== 1'b1) begin errors++; $display("FAIL rm_after got n=%0d b14=%b want 0 1", seen, bricksAlive[14]); end
    endtask

    task automatic test_gap;
        show_pixel(10'd118, 10'd25, 1'b1);
        checks++; if (g_sd !== 1'b1 || g_color !== 8'h00) begin errors++; $display("FAIL gap_118 got sd=%b c=%h want 1 00", g_sd, g_color); end
        show_pixel(10'd117, 10'd25, 1'b1);
        checks++; if (g_sd !== 1'b1 || g_color !== 8'hC0) begin errors++; $display("FAIL gap_117 got sd=%b c=%h want 1 c0", g_sd, g_color); end
        show_pixel(10'd25, 10'd38, 1'b1);
        checks++; if (g_sd !== 1'b1 || g_color !== 8'h00) begin errors++; $display("FAIL gap_y38 got sd=%b c=%h want 1 00", g_sd, g_color); end
        checks++; if (shouldDisplay !== 1'b1 || color !== 8'hC0) begin errors++; $display("FAIL nogap_y38 got sd=%b c=%h want 1 c0", shouldDisplay, color); end
        displayEnable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_hit();
        test_level();
        test_load_collide();
        test_load_lookup();
        test_reset_mid();
        test_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
